// File: rtl/fetch_stage_if.sv
// Front-end bundle between the fetch stage and its neighbours.
// It carries the hazard unit controls, the instruction memory port, the IF/ID
// register outputs and the performance counters.
// The fetch stage takes the master modport. The surrounding pipeline or the
// bench takes the slave modport.
interface fetch_stage_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 load_enable;
  logic                 flush;
  logic [31:0]          redirect_target;
  logic [31:0]          imem_addr;
  logic [31:0]          imem_data;
  logic [31:0]          pc;
  logic [31:0]          fd_instruction;
  logic [31:0]          fd_pc_plus4;
  logic                 fd_valid;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    input  load_enable, flush, redirect_target, imem_data,
    output imem_addr, pc, fd_instruction, fd_pc_plus4, fd_valid,
           stall_count, flush_count
  );

  modport slave (
    output load_enable, flush, redirect_target, imem_data,
    input  imem_addr, pc, fd_instruction, fd_pc_plus4, fd_valid,
           stall_count, flush_count
  );
endinterface

// File: rtl/fetch_stage.sv
// PC register plus IF/ID pipeline register for a 5-stage MIPS pipeline.
// Edge priority is reset > flush > stall > advance.
// A flush redirects the PC to a word-aligned target and loads a bubble into
// IF/ID. A stall holds everything.
// The RUN/BUBBLE state is the same bit as fd_valid.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {
    BUBBLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // Force word alignment even if someone passes an unaligned reset vector.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t               state_reg, state_next;
  logic [31:0]          pc_reg, pc_next;
  logic [31:0]          instr_reg, instr_next;
  logic [31:0]          pc_plus4_reg, pc_plus4_next;
  logic [CNT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_WIDTH-1:0] flush_cnt_reg, flush_cnt_next;
  logic [31:0]          pc_incr;

  // Sequential PC wraps modulo 2^32 with no flag.
  assign pc_incr = pc_reg + 32'd4;

  // Next-state selection: flush beats stall, and stall beats advance.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    instr_next     = instr_reg;
    pc_plus4_next  = pc_plus4_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;

    if (bus.flush) begin
      // A flush always wins. A stall that arrives with it is not counted.
      state_next    = BUBBLE;
      pc_next       = {bus.redirect_target[31:2], 2'b00};
      instr_next    = NOP_INSTR;
      pc_plus4_next = 32'd0;
      if (flush_cnt_reg != CNT_MAX) begin
        flush_cnt_next = flush_cnt_reg + CNT_ONE;
      end
    end else if (!bus.load_enable) begin
      if (stall_cnt_reg != CNT_MAX) begin
        stall_cnt_next = stall_cnt_reg + CNT_ONE;
      end
    end else begin
      state_next    = RUN;
      pc_next       = pc_incr;
      instr_next    = bus.imem_data;
      pc_plus4_next = pc_incr;
    end
  end

  // State registers; an active-low synchronous reset restarts fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= BUBBLE;
      pc_reg        <= RESET_PC_ALIGNED;
      instr_reg     <= NOP_INSTR;
      pc_plus4_reg  <= 32'd0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      instr_reg     <= instr_next;
      pc_plus4_reg  <= pc_plus4_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign bus.imem_addr      = pc_reg;
  assign bus.pc             = pc_reg;
  assign bus.fd_instruction = instr_reg;
  assign bus.fd_pc_plus4    = pc_plus4_reg;
  assign bus.fd_valid       = (state_reg == RUN);
  assign bus.stall_count    = stall_cnt_reg;
  assign bus.flush_count    = flush_cnt_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. The DUT is built with 4-bit counters so
// that saturation can be reached quickly.
// The stimulus pushes the hand-computed outcome of each edge into a queue.
// A monitor pops one entry after every rising edge and compares it against
// the DUT outputs.
// The instruction memory returns addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

  localparam int CW = 4;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [3:0]  stall;
    logic [3:0]  flsh;
  } exp_t;

  logic clk;
  logic rst;
  fetch_stage_if #(.CNT_WIDTH(CW)) bus ();

  exp_t exp_q[$];
  int   passed;
  int   total;
  bit   stim_done;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.imem_data = bus.imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s actual=%08h expected=%08h", nm, field, act, exp);
  endtask

  // Drives one edge worth of inputs and records what that edge must produce.
  task automatic vec(input logic r, input logic le, input logic fl, input logic [31:0] tgt,
                     input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4,
                     input logic ev, input int es, input int ef, input string nm);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    bus.load_enable     = le;
    bus.flush           = fl;
    bus.redirect_target = tgt;
    e.name  = nm;
    e.pc    = epc;
    e.instr = ei;
    e.pc4   = ep4;
    e.valid = ev;
    e.stall = 4'(es);
    e.flsh  = 4'(ef);
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "pc", bus.pc, e.pc);
        chk(e.name, "imem_addr", bus.imem_addr, e.pc);
        chk(e.name, "fd_instruction", bus.fd_instruction, e.instr);
        chk(e.name, "fd_pc_plus4", bus.fd_pc_plus4, e.pc4);
        chk(e.name, "fd_valid", {31'd0, bus.fd_valid}, {31'd0, e.valid});
        chk(e.name, "stall_count", {28'd0, bus.stall_count}, {28'd0, e.stall});
        chk(e.name, "flush_count", {28'd0, bus.flush_count}, {28'd0, e.flsh});
        $display("edge %-12s pc=%08h instr=%08h pc4=%08h v=%0b stall=%0d flush=%0d",
                 e.name, bus.pc, bus.fd_instruction, bus.fd_pc_plus4, bus.fd_valid,
                 bus.stall_count, bus.flush_count);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog expired, stimulus did not complete");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    passed = 0;
    total = 0;
    stim_done = 1'b0;
    rst = 1'b0;
    bus.load_enable = 1'b1;
    bus.flush = 1'b0;
    bus.redirect_target = 32'd0;

    // Reset, including a reset that overrides a simultaneous flush and stall.
    vec(0, 1, 0, 32'h0,  32'h0, 32'h0, 32'h0, 0, 0, 0, "reset");
    vec(0, 0, 1, 32'h40, 32'h0, 32'h0, 32'h0, 0, 0, 0, "rst_override");
    // Advance from the reset PC.
    vec(1, 1, 0, 32'h0,  32'h4, 32'hA5A5_0000, 32'h4, 1, 0, 0, "adv0");
    vec(1, 1, 0, 32'h0,  32'h8, 32'hA5A5_0004, 32'h8, 1, 0, 0, "adv1");
    // Three-cycle stall at PC=8.
    for (int k = 1; k <= 3; k++)
      vec(1, 0, 0, 32'h0, 32'h8, 32'hA5A5_0004, 32'h8, 1, k, 0, "stall3");
    vec(1, 1, 0, 32'h0,  32'hC, 32'hA5A5_0008, 32'hC, 1, 3, 0, "release");
    // Flush together with a stall: alignment applied, stall not counted.
    vec(1, 0, 1, 32'h0000_0103, 32'h100, 32'h0, 32'h0, 0, 3, 1, "flush_stall");
    vec(1, 1, 0, 32'h0, 32'h104, 32'hA5A5_0100, 32'h104, 1, 3, 1, "tgt_fetch");
    // Back-to-back flushes.
    vec(1, 1, 1, 32'h200, 32'h200, 32'h0, 32'h0, 0, 3, 2, "flush_b2b_a");
    vec(1, 0, 1, 32'h302, 32'h300, 32'h0, 32'h0, 0, 3, 3, "flush_b2b_b");
    // PC wrap: redirect to the last word, then advance past 2^32.
    vec(1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 3, 4, "flush_top");
    vec(1, 1, 0, 32'h0, 32'h0, 32'h5A5A_FFFC, 32'h0, 1, 3, 4, "wrap_adv");
    vec(1, 1, 0, 32'h0, 32'h4, 32'hA5A5_0000, 32'h4, 1, 3, 4, "post_wrap");
    // Long stall: the stall counter saturates at 15.
    for (int k = 1; k <= 20; k++)
      vec(1, 0, 0, 32'h0, 32'h4, 32'hA5A5_0000, 32'h4, 1, (3 + k > 15) ? 15 : 3 + k, 4, "stall_sat");
    // Repeated flushes: the flush counter saturates at 15.
    for (int k = 1; k <= 13; k++)
      vec(1, 1, 1, 32'(k * 16), 32'(k * 16), 32'h0, 32'h0, 0, 15, (4 + k > 15) ? 15 : 4 + k, "flush_sat");
    // A stall while a bubble sits in IF/ID holds the bubble.
    vec(1, 0, 0, 32'h0, 32'hD0, 32'h0, 32'h0, 0, 15, 15, "bubble_hold");
    // Reset in the middle of a stall, then restart at the reset PC.
    vec(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, "rst_midstall");
    vec(1, 1, 0, 32'h0, 32'h4, 32'hA5A5_0000, 32'h4, 1, 0, 0, "restart");

    @(negedge clk);
    bus.load_enable = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
